// File: rtl/pi1_dcache_arb.sv
// pi1_dcache_arb: shares one pi1 data-cache slave port between MASTERCOUNT
// pi1 masters with round-robin grant, and sequences cache flushes
// (drain owner -> crst pulse -> hold-off sweep of CACHESETCOUNT+1 cycles).
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-low reset
//   flush_i               level flush request
//   flush_done_o          one-cycle pulse at end of the post-flush sweep
//   crst_o, cmiss_o       to cache crst_i / cmiss_i
//   gnt_o                 one-hot current owner, 0 when none
//   m_pi1_*               packed per-master request buses, per-master ready,
//                         broadcast read data
//   s_pi1_*               muxed request to the cache, response from it
module pi1_dcache_arb #(
  parameter int unsigned ARCHBITSZ     = 32,
  parameter int unsigned MASTERCOUNT   = 2,
  parameter int unsigned CACHESETCOUNT = 2,
  localparam int unsigned SELBITSZ     = ARCHBITSZ / 8,
  localparam int unsigned ADDRBITSZ    = ARCHBITSZ - $clog2(SELBITSZ),
  localparam int unsigned GW           = $clog2(MASTERCOUNT)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            flush_i,
  output logic                            flush_done_o,
  output logic                            crst_o,
  output logic                            cmiss_o,
  output logic [MASTERCOUNT-1:0]          gnt_o,
  input  logic [2*MASTERCOUNT-1:0]        m_pi1_op_i,
  input  logic [ADDRBITSZ*MASTERCOUNT-1:0] m_pi1_addr_i,
  input  logic [ARCHBITSZ*MASTERCOUNT-1:0] m_pi1_data_i,
  input  logic [SELBITSZ*MASTERCOUNT-1:0] m_pi1_sel_i,
  input  logic [MASTERCOUNT-1:0]          m_cmiss_i,
  output logic [ARCHBITSZ-1:0]            m_pi1_data_o,
  output logic [MASTERCOUNT-1:0]          m_pi1_rdy_o,
  output logic [1:0]                      s_pi1_op_o,
  output logic [ADDRBITSZ-1:0]            s_pi1_addr_o,
  output logic [ARCHBITSZ-1:0]            s_pi1_data_o,
  output logic [SELBITSZ-1:0]             s_pi1_sel_o,
  input  logic [ARCHBITSZ-1:0]            s_pi1_data_i,
  input  logic                            s_pi1_rdy_i
);

  localparam int unsigned CW = $clog2(CACHESETCOUNT) + 1;
  localparam logic [1:0] OP_NOOP = 2'b00;

  typedef enum logic [1:0] {IDLE, OWN, FLUSH, SWEEP} state_t;

  state_t          state;
  logic [GW-1:0]   g;
  logic [CW-1:0]   cnt;

  logic [1:0]           op_arr   [MASTERCOUNT];
  logic [ADDRBITSZ-1:0] addr_arr [MASTERCOUNT];
  logic [ARCHBITSZ-1:0] data_arr [MASTERCOUNT];
  logic [SELBITSZ-1:0]  sel_arr  [MASTERCOUNT];

  logic          any_req;
  logic          owner_done;
  logic [GW-1:0] pick;
  logic          found;
  logic [GW-1:0] cand;

  // Unpack the per-master request buses
  always_comb begin
    for (int unsigned k = 0; k < MASTERCOUNT; k++) begin
      op_arr[k]   = m_pi1_op_i[2*k +: 2];
      addr_arr[k] = m_pi1_addr_i[ADDRBITSZ*k +: ADDRBITSZ];
      data_arr[k] = m_pi1_data_i[ARCHBITSZ*k +: ARCHBITSZ];
      sel_arr[k]  = m_pi1_sel_i[SELBITSZ*k +: SELBITSZ];
    end
  end

  assign any_req = |m_pi1_op_i;

  // Round-robin: scan g+1 .. g+MASTERCOUNT so the last owner is checked last
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 1; i <= MASTERCOUNT; i++) begin
      cand = GW'((32'(g) + i) % MASTERCOUNT);
      if (!found && (op_arr[cand] != OP_NOOP)) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // Owner hands the port back: its final response with no further request
  assign owner_done = (state == OWN) && s_pi1_rdy_i && (op_arr[g] == OP_NOOP);

  // Arbitration / flush sequencing state
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      g     <= GW'(MASTERCOUNT - 1);
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_i) begin
            state <= FLUSH;
          end else if (any_req) begin
            g     <= pick;
            state <= OWN;
          end
        end
        OWN: begin
          if (owner_done) begin
            if (flush_i) begin
              state <= FLUSH;
            end else if (any_req) begin
              g <= pick;
            end else begin
              state <= IDLE;
            end
          end
        end
        FLUSH: begin
          cnt   <= CW'(CACHESETCOUNT);
          state <= SWEEP;
        end
        SWEEP: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m_pi1_data_o = s_pi1_data_i;

  // Slave-side mux and per-master handshakes, decoded from the state flops
  always_comb begin
    s_pi1_op_o   = OP_NOOP;
    s_pi1_addr_o = '0;
    s_pi1_data_o = '0;
    s_pi1_sel_o  = '0;
    cmiss_o      = 1'b0;
    gnt_o        = '0;
    m_pi1_rdy_o  = '0;
    crst_o       = (state == FLUSH);
    flush_done_o = (state == SWEEP) && (cnt == '0);
    if (state == OWN) begin
      s_pi1_op_o   = op_arr[g];
      s_pi1_addr_o = addr_arr[g];
      s_pi1_data_o = data_arr[g];
      s_pi1_sel_o  = sel_arr[g];
      cmiss_o      = m_cmiss_i[g];
      gnt_o        = MASTERCOUNT'(1) << g;
      m_pi1_rdy_o  = (MASTERCOUNT'(1) << g) & {MASTERCOUNT{s_pi1_rdy_i}};
    end
  end

endmodule

// File: tb/tb_pi1_dcache_arb.sv
// Directed bench for pi1_dcache_arb: a 2-master instance with a 4-set cache
// and a 3-master instance for wrap-around arbitration.
module tb_pi1_dcache_arb;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // 2-master instance
  logic        flush, flush_done, crst, cmiss;
  logic [1:0]  gnt, m_rdy, m_cmiss, s_op;
  logic [3:0]  m_op;
  logic [59:0] m_addr;
  logic [63:0] m_data;
  logic [7:0]  m_sel;
  logic [31:0] m_rdata, s_wdata, s_rdata;
  logic [29:0] s_addr;
  logic [3:0]  s_sel;
  logic        s_rdy;

  // 3-master instance
  logic        flush3, flush_done3, crst3, cmiss3;
  logic [2:0]  gnt3, m_rdy3, m_cmiss3;
  logic [1:0]  s_op3;
  logic [5:0]  m_op3;
  logic [89:0] m_addr3;
  logic [95:0] m_data3;
  logic [11:0] m_sel3;
  logic [31:0] m_rdata3, s_wdata3, s_rdata3;
  logic [29:0] s_addr3;
  logic [3:0]  s_sel3;
  logic        s_rdy3;

  pi1_dcache_arb #(.ARCHBITSZ(32), .MASTERCOUNT(2), .CACHESETCOUNT(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush), .flush_done_o(flush_done),
    .crst_o(crst), .cmiss_o(cmiss), .gnt_o(gnt),
    .m_pi1_op_i(m_op), .m_pi1_addr_i(m_addr), .m_pi1_data_i(m_data),
    .m_pi1_sel_i(m_sel), .m_cmiss_i(m_cmiss), .m_pi1_data_o(m_rdata),
    .m_pi1_rdy_o(m_rdy), .s_pi1_op_o(s_op), .s_pi1_addr_o(s_addr),
    .s_pi1_data_o(s_wdata), .s_pi1_sel_o(s_sel), .s_pi1_data_i(s_rdata),
    .s_pi1_rdy_i(s_rdy)
  );

  pi1_dcache_arb #(.ARCHBITSZ(32), .MASTERCOUNT(3), .CACHESETCOUNT(2)) dut3 (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush3), .flush_done_o(flush_done3),
    .crst_o(crst3), .cmiss_o(cmiss3), .gnt_o(gnt3),
    .m_pi1_op_i(m_op3), .m_pi1_addr_i(m_addr3), .m_pi1_data_i(m_data3),
    .m_pi1_sel_i(m_sel3), .m_cmiss_i(m_cmiss3), .m_pi1_data_o(m_rdata3),
    .m_pi1_rdy_o(m_rdy3), .s_pi1_op_o(s_op3), .s_pi1_addr_o(s_addr3),
    .s_pi1_data_o(s_wdata3), .s_pi1_sel_o(s_sel3), .s_pi1_data_i(s_rdata3),
    .s_pi1_rdy_i(s_rdy3)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    m_op = 4'b0010;
    s_rdy = 1'b0;
    cyc(); cyc();
    #1;
    tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL rst_gnt got=%b exp=00", gnt); end
    tests++; if (s_op !== 2'b00) begin fails++; $display("FAIL rst_sop got=%b exp=00", s_op); end
    tests++; if ({crst, flush_done, cmiss} !== 3'b000) begin fails++; $display("FAIL rst_ctl got=%b exp=000", {crst, flush_done, cmiss}); end
    tests++; if (m_rdy !== 2'b00) begin fails++; $display("FAIL rst_rdy got=%b exp=00", m_rdy); end
    rst_i = 1'b1;
    cyc();
    #1;
    tests++; if (gnt !== 2'b01) begin fails++; $display("FAIL first_gnt got=%b exp=01", gnt); end
    tests++; if (s_op !== 2'b10) begin fails++; $display("FAIL first_sop got=%b exp=10", s_op); end
    tests++; if (s_addr !== 30'h10) begin fails++; $display("FAIL first_addr got=%h exp=10", s_addr); end
    tests++; if ({s_wdata, s_sel} !== {32'hAAAA_0000, 4'h3}) begin fails++; $display("FAIL first_wdata got=%h/%h", s_wdata, s_sel); end
    tests++; if (m_rdy !== 2'b00) begin fails++; $display("FAIL first_rdy0 got=%b exp=00", m_rdy); end
    s_rdy = 1'b1;
    #1;
    tests++; if (m_rdy !== 2'b01) begin fails++; $display("FAIL first_rdy1 got=%b exp=01", m_rdy); end
    m_op = 4'b0000;
    s_rdata = 32'hD0D0_0010;
    #1;
    tests++; if ({m_rdy, m_rdata} !== {2'b01, 32'hD0D0_0010}) begin fails++; $display("FAIL first_resp got=%b/%h exp=01/d0d00010", m_rdy, m_rdata); end
    cyc();
    #1;
    tests++; if ({gnt, m_rdy, s_op} !== 6'b0) begin fails++; $display("FAIL idle_after got=%b exp=000000", {gnt, m_rdy, s_op}); end
    tests++; if ({s_addr, s_wdata, s_sel} !== 66'b0) begin fails++; $display("FAIL idle_bus got=%h/%h/%h exp=0", s_addr, s_wdata, s_sel); end
  endtask

  task automatic test_alternate();
    int exp_g;
    m_op = 4'b1010;
    s_rdy = 1'b0;
    cyc();
    exp_g = 1;
    for (int i = 0; i < 4; i++) begin
      m_op = 4'b1010;
      s_rdy = 1'b0;
      #1;
      tests++; if (gnt !== 2'(1 << exp_g)) begin fails++; $display("FAIL alt_gnt[%0d] got=%b exp_owner=%0d", i, gnt, exp_g); end
      tests++; if (s_addr !== ((exp_g == 1) ? 30'h2B : 30'h10)) begin fails++; $display("FAIL alt_addr[%0d] got=%h", i, s_addr); end
      tests++; if (m_rdy !== 2'b00) begin fails++; $display("FAIL alt_rdy0[%0d] got=%b exp=00", i, m_rdy); end
      cyc();
      m_op = (exp_g == 1) ? 4'b0010 : 4'b1000;
      s_rdy = 1'b1;
      s_rdata = 32'hA0 + 32'(i);
      #1;
      tests++; if (m_rdy !== 2'(1 << exp_g)) begin fails++; $display("FAIL alt_rdy1[%0d] got=%b exp_owner=%0d", i, m_rdy, exp_g); end
      tests++; if (m_rdata !== 32'hA0 + 32'(i)) begin fails++; $display("FAIL alt_data[%0d] got=%h", i, m_rdata); end
      cyc();
      exp_g = 1 - exp_g;
    end
    m_op = 4'b0000;
    s_rdy = 1'b1;
    cyc();
    tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL alt_end got=%b exp=00", gnt); end
  endtask

  task automatic test_rw();
    m_op = 4'b1100;
    m_cmiss = 2'b10;
    s_rdy = 1'b0;
    cyc();
    m_op = 4'b1110;
    #1;
    tests++; if ({gnt, s_op, cmiss, m_rdy} !== 7'b10_11_1_00) begin fails++; $display("FAIL rw_own got=%b exp=1011100", {gnt, s_op, cmiss, m_rdy}); end
    m_cmiss = 2'b01;
    #1;
    tests++; if (cmiss !== 1'b0) begin fails++; $display("FAIL rw_cmiss got=%b exp=0", cmiss); end
    s_rdy = 1'b1;
    #1;
    tests++; if (m_rdy !== 2'b10) begin fails++; $display("FAIL rw_resp got=%b exp=10", m_rdy); end
    cyc();
    s_rdy = 1'b0;
    #1;
    tests++; if (gnt !== 2'b10) begin fails++; $display("FAIL rw_hold got=%b exp=10", gnt); end
    m_op = 4'b0010;
    s_rdy = 1'b1;
    #1;
    tests++; if (m_rdy !== 2'b10) begin fails++; $display("FAIL rw_release got=%b exp=10", m_rdy); end
    cyc();
    s_rdy = 1'b0;
    #1;
    tests++; if ({gnt, s_op} !== 4'b01_10) begin fails++; $display("FAIL rw_handover got=%b exp=0110", {gnt, s_op}); end
    m_op = 4'b0000;
    m_cmiss = 2'b00;
    s_rdy = 1'b1;
    cyc();
  endtask

  task automatic test_flush();
    m_op = 4'b0010;
    s_rdy = 1'b0;
    cyc();
    flush = 1'b1;
    #1;
    tests++; if ({gnt, crst} !== 3'b01_0) begin fails++; $display("FAIL fl_own got=%b exp=010", {gnt, crst}); end
    cyc();
    tests++; if (gnt !== 2'b01) begin fails++; $display("FAIL fl_nopreempt got=%b exp=01", gnt); end
    m_op = 4'b1000;
    s_rdy = 1'b1;
    s_rdata = 32'h5555_AAAA;
    #1;
    tests++; if ({m_rdy, m_rdata} !== {2'b01, 32'h5555_AAAA}) begin fails++; $display("FAIL fl_drain got=%b/%h", m_rdy, m_rdata); end
    cyc();
    tests++; if ({crst, m_rdy, gnt, s_op} !== 7'b1_00_00_00) begin fails++; $display("FAIL fl_crst got=%b exp=1000000", {crst, m_rdy, gnt, s_op}); end
    cyc();
    for (int j = 0; j < 5; j++) begin
      #1;
      tests++; if ({crst, m_rdy, gnt} !== 5'b0) begin fails++; $display("FAIL fl_sweep[%0d] got=%b exp=00000", j, {crst, m_rdy, gnt}); end
      tests++; if (flush_done !== (j == 4)) begin fails++; $display("FAIL fl_done[%0d] got=%b exp=%b", j, flush_done, (j == 4)); end
      if (j == 4) flush = 1'b0;
      cyc();
    end
    tests++; if ({gnt, flush_done} !== 3'b0) begin fails++; $display("FAIL fl_idle got=%b exp=000", {gnt, flush_done}); end
    cyc();
    tests++; if (gnt !== 2'b10) begin fails++; $display("FAIL fl_regrant got=%b exp=10", gnt); end
    m_op = 4'b0000;
    cyc();
  endtask

  task automatic test_flush_priority_reset();
    m_op = 4'b0010;
    flush = 1'b1;
    s_rdy = 1'b1;
    #1;
    tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL pr_idle got=%b exp=00", gnt); end
    cyc();
    tests++; if ({crst, gnt} !== 3'b1_00) begin fails++; $display("FAIL pr_flushwins got=%b exp=100", {crst, gnt}); end
    flush = 1'b0;
    m_op = 4'b0000;
    cyc();
    rst_i = 1'b0;
    #1;
    tests++; if ({crst, flush_done} !== 2'b00) begin fails++; $display("FAIL sr_async got=%b exp=00", {crst, flush_done}); end
    cyc();
    rst_i = 1'b1;
    m_op = 4'b0010;
    s_rdy = 1'b0;
    #1;
    tests++; if ({gnt, crst} !== 3'b0) begin fails++; $display("FAIL sr_idle got=%b exp=000", {gnt, crst}); end
    cyc();
    tests++; if (gnt !== 2'b01) begin fails++; $display("FAIL sr_grant got=%b exp=01", gnt); end
    for (int j = 0; j < 6; j++) begin
      tests++; if (flush_done !== 1'b0) begin fails++; $display("FAIL sr_nodone[%0d] got=%b exp=0", j, flush_done); end
      cyc();
    end
    m_op = 4'b0000;
    s_rdy = 1'b1;
    cyc();
  endtask

  task automatic test_mc3();
    s_rdy3 = 1'b0;
    m_op3 = 6'b10_00_00;
    cyc();
    tests++; if ({gnt3, s_addr3} !== {3'b100, 30'h32}) begin fails++; $display("FAIL m3_own2 got=%b/%h exp=100/32", gnt3, s_addr3); end
    m_op3 = 6'b00_10_10;
    s_rdy3 = 1'b1;
    #1;
    tests++; if (m_rdy3 !== 3'b100) begin fails++; $display("FAIL m3_rel2 got=%b exp=100", m_rdy3); end
    cyc();
    tests++; if ({gnt3, s_addr3} !== {3'b001, 30'h30}) begin fails++; $display("FAIL m3_wrap got=%b/%h exp=001/30", gnt3, s_addr3); end
    m_op3 = 6'b10_10_00;
    cyc();
    tests++; if (gnt3 !== 3'b010) begin fails++; $display("FAIL m3_next1 got=%b exp=010", gnt3); end
    m_op3 = 6'b10_00_10;
    cyc();
    tests++; if (gnt3 !== 3'b100) begin fails++; $display("FAIL m3_next2 got=%b exp=100", gnt3); end
    m_op3 = 6'b00_00_10;
    cyc();
    tests++; if (gnt3 !== 3'b001) begin fails++; $display("FAIL m3_next0 got=%b exp=001", gnt3); end
    m_op3 = 6'b00_00_00;
    cyc();
    tests++; if (gnt3 !== 3'b000) begin fails++; $display("FAIL m3_idle got=%b exp=000", gnt3); end
    m_op3 = 6'b00_00_10;
    cyc();
    tests++; if (gnt3 !== 3'b001) begin fails++; $display("FAIL m3_self got=%b exp=001", gnt3); end
    m_op3 = 6'b00_00_00;
    cyc();
  endtask

  initial begin
    rst_i   = 1'b0;
    flush   = 1'b0;
    m_op    = '0;
    m_addr  = {30'h2B, 30'h10};
    m_data  = {32'hBBBB_0001, 32'hAAAA_0000};
    m_sel   = {4'hC, 4'h3};
    m_cmiss = '0;
    s_rdata = '0;
    s_rdy   = 1'b0;
    flush3   = 1'b0;
    m_op3    = '0;
    m_addr3  = {30'h32, 30'h31, 30'h30};
    m_data3  = {32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
    m_sel3   = {4'h4, 4'h2, 4'h1};
    m_cmiss3 = '0;
    s_rdata3 = '0;
    s_rdy3   = 1'b0;
    test_reset();
    test_alternate();
    test_rw();
    test_flush();
    test_flush_priority_reset();
    test_mc3();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
